// File: rtl/pwm_capture_if.sv
// pwm_capture_if: bundles the PWM input and the measurement results of pwm_capture.
//   master : the capture block (samples pwm_in, drives the results)
//   slave  : the consumer (drives pwm_in, reads the results)
// Signals: pwm_in, high_count/period_count [CNT_W], meas_valid, stuck_high,
//          stuck_low, duty_pct [7], pct_valid.
`timescale 1ns/1ps
interface pwm_capture_if #(
  parameter int CNT_W = 16
);
  logic             pwm_in;
  logic [CNT_W-1:0] high_count;
  logic [CNT_W-1:0] period_count;
  logic             meas_valid;
  logic             stuck_high;
  logic             stuck_low;
  logic [6:0]       duty_pct;
  logic             pct_valid;

  modport master (
    input  pwm_in,
    output high_count, period_count, meas_valid, stuck_high, stuck_low,
           duty_pct, pct_valid
  );

  modport slave (
    output pwm_in,
    input  high_count, period_count, meas_valid, stuck_high, stuck_low,
           duty_pct, pct_valid
  );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period (in clk cycles) of an asynchronous
// PWM input for every complete waveform cycle and flags inputs stuck at a level.
// Optional integer duty-percentage divider enabled by macro PWM_CAPTURE_PCT_EN.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - pwm_capture_if.master: pwm_in in; high_count, period_count,
//          meas_valid, stuck_high, stuck_low, duty_pct, pct_valid out
// Parameters: CNT_W counter/output width, TIMEOUT stuck detection in cycles
// (2 <= TIMEOUT <= 2^CNT_W-1).
`timescale 1ns/1ps
module pwm_capture #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic          clk,
  input  logic          rst,
  pwm_capture_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_HIT  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t           state, state_next;
  logic             s1, s2, s3;
  logic [2:0]       fill;
  logic             rise, fall;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] age;
  logic [CNT_W-1:0] high_latch;
  logic             timeout, latch_high, publish;
  logic [CNT_W-1:0] high_count_r, period_count_r;
  logic             meas_valid_r, stuck_high_r, stuck_low_r;

  // Synchronizer + edge-detect register. The reset contents of the chain are
  // not real samples, so strobes are held off until the chain has refilled;
  // otherwise an input already high at reset release would look like a rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      fill <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= bus.pwm_in;
      s2   <= s1;
      s3   <= s2;
      fill <= {fill[1:0], 1'b1};
      rise <= fill[2] & s2 & ~s3;
      fall <= fill[2] & ~s2 & s3;
    end
  end

  // cnt: cycles since the last rise (period / high time).
  // age: cycles since the last edge of either polarity (stuck detection).
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      age <= '0;
    end else begin
      if (rise)                cnt <= ONE;
      else if (cnt != CNT_MAX) cnt <= cnt + ONE;
      if (rise || fall)        age <= ONE;
      else if (age != CNT_MAX) age <= age + ONE;
    end
  end

  assign timeout = ~rise & ~fall & (age == TO_HIT);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    latch_high = 1'b0;
    publish    = 1'b0;
    if (timeout) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (rise) state_next = HIGH;
        HIGH: if (fall) begin
          state_next = LOW;
          latch_high = 1'b1;
        end
        LOW: if (rise) begin
          state_next = HIGH;
          publish    = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      high_latch     <= '0;
      high_count_r   <= '0;
      period_count_r <= '0;
      meas_valid_r   <= 1'b0;
      stuck_high_r   <= 1'b0;
      stuck_low_r    <= 1'b0;
    end else begin
      meas_valid_r <= publish;
      if (latch_high) high_latch <= cnt;
      if (publish) begin
        high_count_r   <= high_latch;
        period_count_r <= cnt;
        stuck_high_r   <= 1'b0;
        stuck_low_r    <= 1'b0;
      end
      if (timeout) begin
        stuck_high_r <= s3;
        stuck_low_r  <= ~s3;
      end
    end
  end

  assign bus.high_count   = high_count_r;
  assign bus.period_count = period_count_r;
  assign bus.meas_valid   = meas_valid_r;
  assign bus.stuck_high   = stuck_high_r;
  assign bus.stuck_low    = stuck_low_r;

`ifdef PWM_CAPTURE_PCT_EN
  localparam int DW = CNT_W + 7;

  logic [DW-1:0]    rem, trial;
  logic [CNT_W-1:0] dvs;
  logic [6:0]       quo, quo_next;
  logic [2:0]       idx;
  logic             busy, ge;
  logic [6:0]       duty_r;
  logic             pct_r;

  // Restoring division producing one quotient bit per cycle, MSB first:
  // subtract divisor<<idx whenever it fits into the running remainder.
  always_comb begin
    trial    = DW'(dvs) << idx;
    ge       = (rem >= trial);
    quo_next = quo | (ge ? (7'd1 << idx) : 7'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem    <= '0;
      dvs    <= '0;
      quo    <= '0;
      idx    <= '0;
      busy   <= 1'b0;
      duty_r <= '0;
      pct_r  <= 1'b0;
    end else begin
      pct_r <= 1'b0;
      if (meas_valid_r) begin
        // a fresh measurement always restarts, dropping any result in flight
        rem  <= DW'(high_count_r) * DW'(100);
        dvs  <= period_count_r;
        quo  <= '0;
        idx  <= 3'd6;
        busy <= 1'b1;
      end else if (busy) begin
        quo <= quo_next;
        if (ge) rem <= rem - trial;
        if (idx == 3'd0) begin
          busy   <= 1'b0;
          duty_r <= quo_next;
          pct_r  <= 1'b1;
        end else begin
          idx <= idx - 3'd1;
        end
      end
    end
  end

  assign bus.duty_pct  = duty_r;
  assign bus.pct_valid = pct_r;
`else
  assign bus.duty_pct  = '0;
  assign bus.pct_valid = 1'b0;
`endif

endmodule
